// File: rtl/core_pkg.sv
// Shared core types: fetch fault encoding and the canonical NOP encoding.
package core_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_ACCESS     = 2'd2
  } fetch_fault_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/core_fetch_if.sv
// Instruction-memory request/response channel between the fetch stage and the bus.
interface core_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );
endinterface

// File: rtl/core_fetch.sv
// Fetch stage: holds the PC, issues one imem read at a time and presents the
// returned instruction to exec until it retires or a redirect arrives.
module core_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  core_fetch_if.master      imem,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       pc,
  output fetch_fault_e      fetch_fault,
  input  logic              instr_done,
  input  logic [31:0]       next_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e       r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  fetch_fault_e r_fault;
  logic         r_discard;

  logic w_aligned;
  logic w_req_fire;

  assign w_aligned           = (r_pc[1:0] == 2'b00);
  assign imem.imem_req_valid = rst_n && (r_state == S_REQ) && w_aligned;
  assign imem.imem_req_addr  = r_pc;
  assign w_req_fire          = imem.imem_req_valid && imem.imem_req_ready;

  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign fetch_fault = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= INSTR_NOP;
      r_instr_valid <= 1'b0;
      r_fault       <= FAULT_NONE;
      r_discard     <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_pc          <= redirect_pc;
        r_instr_valid <= 1'b0;
        r_fault       <= FAULT_NONE;
      end
      unique case (r_state)
        S_REQ: begin
          // A request accepted in the redirect cycle is still in flight; its data must be dropped.
          if (redirect_valid) begin
            if (w_req_fire) begin
              r_state   <= S_WAIT;
              r_discard <= 1'b1;
            end
          end else if (!w_aligned) begin
            r_fault       <= FAULT_MISALIGNED;
            r_instr       <= INSTR_NOP;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end else if (imem.imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            if (imem.imem_rsp_valid) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_discard <= 1'b1;
            end
          end else if (imem.imem_rsp_valid) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_instr       <= imem.imem_rsp_data;
              r_fault       <= imem.imem_rsp_err ? FAULT_ACCESS : FAULT_NONE;
              r_instr_valid <= 1'b1;
              r_state       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_state <= S_REQ;
          end else if (instr_done) begin
            r_pc          <= next_pc;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch: bus handshakes, stalls, faults, redirects and async reset.
module tb_core_fetch;
  import core_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  pc;
  fetch_fault_e fetch_fault;
  logic         instr_done = 1'b0;
  logic [31:0]  next_pc = 32'h0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;

  int total = 0;
  int bad   = 0;

  core_fetch_if bus ();

  core_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc             (pc),
    .fetch_fault    (fetch_fault),
    .instr_done     (instr_done),
    .next_pc        (next_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flt();
    return {30'b0, fetch_fault};
  endfunction

  task automatic chk_hold(input string tag, input logic [31:0] e_instr,
                          input logic [31:0] e_pc, input logic [31:0] e_fault);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, e_instr);
    check({tag, "_pc"},    pc, e_pc);
    check({tag, "_fault"}, flt(), e_fault);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] e_addr);
    check({tag, "_reqv"},   {31'b0, bus.imem_req_valid}, 32'd1);
    check({tag, "_addr"},   bus.imem_req_addr, e_addr);
    check({tag, "_ivalid"}, {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ivalid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr",  instr, 32'h0000_0013);
    check("rst_pc",     pc, 32'h8000_0000);
    check("rst_fault",  flt(), 32'd0);
    check("rst_reqv",   {31'b0, bus.imem_req_valid}, 32'd0);

    // 1: zero-wait fetch at RESET_PC
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b1;
    #1 chk_req("t1_c0", 32'h8000_0000);
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    check("t1_c1_reqv", {31'b0, bus.imem_req_valid}, 32'd0);
    check("t1_c1_ivalid", {31'b0, instr_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0010_0093;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk_hold("t1_c2", 32'h0010_0093, 32'h8000_0000, 32'd0);

    // 2: sequential next PC with a 3-cycle request stall
    instr_done = 1'b1; next_pc = 32'h8000_0004;
    @(negedge clk);
    instr_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_req($sformatf("t2_stall%0d", i), 32'h8000_0004);
      @(negedge clk);
    end
    chk_req("t2_go", 32'h8000_0004);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    check("t2_wait_ivalid", {31'b0, instr_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0513;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk_hold("t2_hold", 32'h0000_0513, 32'h8000_0004, 32'd0);

    // 3: misaligned target raises a fault without a bus request
    instr_done = 1'b1; next_pc = 32'h8000_0102;
    @(negedge clk);
    instr_done = 1'b0;
    check("t3_noreq", {31'b0, bus.imem_req_valid}, 32'd0);
    check("t3_ivalid0", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    check("t3_noreq2", {31'b0, bus.imem_req_valid}, 32'd0);
    chk_hold("t3_hold", 32'h0000_0013, 32'h8000_0102, 32'd1);

    // 4: access fault, then redirect (overriding a same-cycle instr_done)
    instr_done = 1'b1; next_pc = 32'h8000_0108;
    @(negedge clk);
    instr_done = 1'b0;
    chk_req("t4_req", 32'h8000_0108);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_err = 1'b1; bus.imem_rsp_data = 32'h0;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_err = 1'b0;
    chk_hold("t4_err", 32'h0, 32'h8000_0108, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    instr_done = 1'b1; next_pc = 32'h8000_010C;
    @(negedge clk);
    redirect_valid = 1'b0; instr_done = 1'b0;
    check("t4_redir_fault", flt(), 32'd0);
    check("t4_redir_pc", pc, 32'h8000_0200);
    chk_req("t4_redir", 32'h8000_0200);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0020_0113;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk_hold("t4_hold", 32'h0020_0113, 32'h8000_0200, 32'd0);

    // 5: redirect while waiting; the late response must be dropped
    instr_done = 1'b1; next_pc = 32'h8000_0204;
    @(negedge clk);
    instr_done = 1'b0;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t5_w1_ivalid", {31'b0, instr_valid}, 32'd0);
    check("t5_w1_reqv", {31'b0, bus.imem_req_valid}, 32'd0);
    @(negedge clk);
    check("t5_w2_reqv", {31'b0, bus.imem_req_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk_req("t5_rereq", 32'h8000_0300);
    check("t5_nobeef", instr, 32'h0020_0113);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0030_0193;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk_hold("t5_hold", 32'h0030_0193, 32'h8000_0300, 32'd0);

    // 6: async reset in the middle of a wait, stale response afterwards
    instr_done = 1'b1; next_pc = 32'h8000_0304;
    @(negedge clk);
    instr_done = 1'b0;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ivalid", {31'b0, instr_valid}, 32'd0);
    check("t6_rst_instr",  instr, 32'h0000_0013);
    check("t6_rst_pc",     pc, 32'h8000_0000);
    check("t6_rst_fault",  flt(), 32'd0);
    check("t6_rst_reqv",   {31'b0, bus.imem_req_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk_req("t6_restart", 32'h8000_0000);
    check("t6_stale_instr", instr, 32'h0000_0013);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0010_0093;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk_hold("t6_hold", 32'h0010_0093, 32'h8000_0000, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
